pallette_sched: RTL
===================

# pallette_sched

Frame-synchronous scheduler for the VGA palette datapath. It accepts palette-select change requests from the SoC register side and holds each one pending until the next vertical-blank start, so the palette never switches mid-frame. It also runs the text-mode blink timer: when blink is enabled, characters with the blink attribute have their foreground replaced by their background every other blink half-period. It sits between the character/attribute fetch stage and the palette controller, driving the palette `select`, `fg` and `bg` inputs.

## Interface

Parameters:
- `BLINK_FRAMES`, default 32: frames per blink half-period; legal range 2..64.
- `CNT_W`, default 6: width of the frame counter; must satisfy 2^CNT_W >= BLINK_FRAMES.

Ports:
- `clk`  in  1  pixel clock; single clock domain; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `vsync_start`  in  1  one-cycle pulse on the first pixel clock of vertical blank.
- `req_valid`  in  1  request valid, driven by the register side.
- `req_ready`  out  1  request accepted in any cycle where `req_valid && req_ready`.
- `req_select`  in  2  requested palette index, 0..3.
- `req_blink_en`  in  1  requested blink enable.
- `fg_in`  in  4  foreground colour index from the attribute fetch.
- `bg_in`  in  4  background colour index from the attribute fetch.
- `blink_attr`  in  1  blink attribute bit of the current character.
- `select`  out  2  palette select to the palette controller.
- `fg`  out  4  foreground index to the palette, registered.
- `bg`  out  4  background index to the palette, registered.
- `blink_phase`  out  1  current blink phase; 1 = hidden.
- `pending`  out  1  a request has been accepted and is not yet applied.

## Operation

- State machine states:
  - IDLE: `req_ready`=1.
  - PEND: `req_ready`=0, `pending`=1.
  - APPLY: `req_ready`=0, `pending`=1.
- Transitions:
  - IDLE→PEND on handshake; `req_select` and `req_blink_en` are captured into shadow registers.
  - PEND→APPLY on `vsync_start`.
  - APPLY→IDLE unconditionally after one cycle. In that cycle `select` and the active `blink_en` load from the shadow registers.
- Same-cycle handshake and `vsync_start` in IDLE: the request goes to PEND and applies at the *following* `vsync_start`, never at the current one.
- `vsync_start` in APPLY is ignored for the transition. The blink counter still counts it.
- Back-to-back requests: the second request waits in IDLE (`req_valid` held high) until the machine returns to IDLE. No request is dropped and none is overwritten.
- Blink counter `frame_cnt` (CNT_W bits):
  - Increments on each `vsync_start` while the active `blink_en`=1.
  - When at BLINK_FRAMES-1 on `vsync_start`, it wraps to 0 and toggles `blink_phase`.
- When the active `blink_en`=0, `frame_cnt` and `blink_phase` are held at 0.
- When APPLY changes `blink_en` from 0 to 1, counting starts from 0 / phase 0.
- Attribute path, registered every cycle:
  - `bg` <= `bg_in`.
  - `fg` <= `bg_in` if `blink_attr && blink_phase`; otherwise `fg` <= `fg_in`.
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE; shadow registers, `select`, active `blink_en`, `frame_cnt`, `blink_phase`, `fg` and `bg` all go to 0.
  - `pending`=0.
  - `req_ready` is forced to 0 while `rst_n`=0.
  - A pending request at the time of reset is discarded.

## Timing

- `req_ready` is combinational: (state==IDLE) && `rst_n`.
- `pending` is decoded from state and is not registered.
- Apply latency:
  - `vsync_start` sampled in PEND at edge N → state APPLY after edge N.
  - `select` shows the new value after edge N+1.
  - The palette output therefore switches within vertical blank, with 2 palette cycles after that.
- Attribute path latency is 1 cycle, so total `fg_in` → RGB latency is 3 cycles (1 here + 2 in the palette controller). Sync signals must be delayed by 3 cycles to match.
- `blink_phase` toggles after the edge that samples the wrapping `vsync_start`. The attribute path uses the new phase from the next cycle.
- No combinational path runs from `req_valid` to `req_ready`.

## Test plan

- Reset check: hold `rst_n`=0 for 3 cycles with `req_valid`=1 → `req_ready`=0, `select`=0, `fg`=`bg`=0, `pending`=0. After release, `req_ready`=1 the next cycle.
- Deferred switch: request `req_select`=2 mid-frame → `pending`=1 and `select` stays 0. Pulse `vsync_start` → `select`=2 exactly 2 edges later and `pending`=0.
- Simultaneous event: handshake `req_select`=3 in the same cycle as `vsync_start` → `select` unchanged through that vblank; it becomes 3 after the next `vsync_start` + 2 cycles.
- Back-to-back: hold `req_valid`=1 with select 1, then select 2 → second accepted only after APPLY. Final `select`=2 after two vsync pulses; both values are observed in order.
- Blink: BLINK_FRAMES=4, enable blink, drive `fg_in`=0xF, `bg_in`=0x1, `blink_attr`=1 → `fg`=0xF for 4 frames, then 0x1 for 4 frames, repeating. With `blink_attr`=0, `fg` stays 0xF.
- Reset mid-operation: assert `rst_n`=0 while in PEND with `req_select`=1 → after release `select`=0, `pending`=0, and no switch occurs at the next `vsync_start`.

Source files
------------

// File: rtl/pallette_sched_if.sv
// Request handshake between the SoC register side and the palette scheduler.
interface pallette_sched_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_select;
    logic       req_blink_en;

    modport master (
        output req_valid,
        output req_select,
        output req_blink_en,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_select,
        input  req_blink_en,
        output req_ready
    );
endinterface

// File: rtl/pallette_sched.sv
// Frame-synchronous palette scheduler: defers palette/blink changes to vertical
// blank and runs the text-mode blink timer feeding the palette fg/bg indices.
module pallette_sched #(
    parameter  int unsigned BLINK_FRAMES = 32,
    parameter  int unsigned CNT_W        = 6,
    localparam int unsigned SEL_W        = 2,
    localparam int unsigned COL_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pallette_sched_if.slave  req,
    input  logic             vsync_start,
    input  logic [COL_W-1:0] fg_in,
    input  logic [COL_W-1:0] bg_in,
    input  logic             blink_attr,
    output logic [SEL_W-1:0] select,
    output logic [COL_W-1:0] fg,
    output logic [COL_W-1:0] bg,
    output logic             blink_phase,
    output logic             pending
);
    localparam logic [CNT_W-1:0] WRAP = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic [SEL_W-1:0]   shadow_select;
    logic               shadow_blink_en;
    logic               blink_en;
    logic [CNT_W-1:0]   frame_cnt;

    assign accept = req.req_valid && req.req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a vsync coinciding with acceptance is not the one that applies
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)      state_nxt = PEND;
            PEND:    if (vsync_start) state_nxt = APPLY;
            APPLY:                    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req.req_ready = 1'b0;
        pending       = 1'b0;
        unique case (state)
            IDLE:        req.req_ready = rst_n;
            PEND, APPLY: pending       = 1'b1;
            default:     pending       = 1'b0;
        endcase
    end

    // Shadow capture on handshake, activation on leaving APPLY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_select   <= '0;
            shadow_blink_en <= 1'b0;
            select          <= '0;
            blink_en        <= 1'b0;
        end else begin
            if (accept) begin
                shadow_select   <= req.req_select;
                shadow_blink_en <= req.req_blink_en;
            end
            if (state == APPLY) begin
                select   <= shadow_select;
                blink_en <= shadow_blink_en;
            end
        end
    end

    // Blink timer; held clear while blink is off so enabling starts at phase 0
    always_ff @(posedge clk) begin
        if (!rst_n || !blink_en || (state == APPLY && !shadow_blink_en)) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (vsync_start) begin
            if (frame_cnt == WRAP) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Attribute path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fg <= '0;
            bg <= '0;
        end else begin
            bg <= bg_in;
            fg <= (blink_attr && blink_phase) ? bg_in : fg_in;
        end
    end
endmodule
